// File: rtl/glb_stream_writer.sv
// glb_stream_writer: preloadable buffer streamed over ready/valid with base/length/stride
// addressing, optional inter-beat gap, 1-cycle SRAM read and a 2-entry output skid buffer.
`default_nettype none

module glb_stream_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = 16,
   parameter int GAP_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_en,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [ADDR_WIDTH-1:0] cfg_stride,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, issued_q, issued_d;
   logic [GAP_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
   logic                  pend_q, pend_d, pend_last_q, pend_last_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sk0_data_q, sk0_data_d, sk1_data_q, sk1_data_d;
   logic                  sk0_last_q, sk0_last_d, sk1_last_q, sk1_last_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   logic       accept_start, head_valid, pop, push, rd_en, rd_last;
   logic [2:0] occ;

   assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
   assign head_valid   = (cnt_q != 2'd0) && (gap_cnt_q == '0);
   assign pop          = head_valid && ready;
   assign push         = pend_q;
   // Occupancy the skid will have at the next edge; a read issued now lands one edge later.
   assign occ          = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
   assign rd_en        = (state_q == S_RUN) && (occ <= 3'd1);
   assign rd_last      = (issued_q == len_q - 1'b1);

   // Buffer: writes only while not streaming, so reads and writes never collide.
   always_ff @(posedge clk) begin
      if (ld_en && !busy) mem[ld_addr] <= ld_data;
      if (rd_en) rdata_q <= mem[addr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = (cfg_len == '0) ? S_DONE : S_RUN;
         S_RUN:          if (rd_en && rd_last) state_d = S_DRAIN;
         S_DRAIN:        if (pop && sk0_last_q) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid = head_valid;
      data  = sk0_data_q;
      last  = sk0_last_q && head_valid;
      busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
      done  = (state_q == S_DONE);
   end

   always_comb begin
      addr_d      = addr_q;
      stride_d    = stride_q;
      len_d       = len_q;
      gap_d       = gap_q;
      issued_d    = issued_q;
      gap_cnt_d   = gap_cnt_q;
      pend_d      = rd_en;
      pend_last_d = rd_en && rd_last;
      cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
      sk0_data_d  = sk0_data_q;
      sk0_last_d  = sk0_last_q;
      sk1_data_d  = sk1_data_q;
      sk1_last_d  = sk1_last_q;
      if (accept_start) begin
         addr_d    = cfg_base;
         stride_d  = cfg_stride;
         len_d     = cfg_len;
         gap_d     = cfg_gap;
         issued_d  = '0;
         gap_cnt_d = '0;
      end else begin
         if (rd_en) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + 1'b1;
         end
         if (pop)                   gap_cnt_d = gap_q;
         else if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      end
      if (pop) begin
         sk0_data_d = sk1_data_q;
         sk0_last_d = sk1_last_q;
      end
      if (push) begin
         if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
            sk0_data_d = rdata_q;
            sk0_last_d = pend_last_q;
         end else begin
            sk1_data_d = rdata_q;
            sk1_last_d = pend_last_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         stride_q    <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         issued_q    <= '0;
         gap_cnt_q   <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         cnt_q       <= 2'd0;
         sk0_data_q  <= '0;
         sk0_last_q  <= 1'b0;
         sk1_data_q  <= '0;
         sk1_last_q  <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         issued_q    <= issued_d;
         gap_cnt_q   <= gap_cnt_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         cnt_q       <= cnt_d;
         sk0_data_q  <= sk0_data_d;
         sk0_last_q  <= sk0_last_d;
         sk1_data_q  <= sk1_data_d;
         sk1_last_q  <= sk1_last_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/glb_stream_writer.md
Name: glb_stream_writer

Overview:
- Parametrised, synthesizable stream source that feeds a fabric input port the way a GLB tile does in memory-core tests.
- Holds a preloadable local buffer and streams a configured window of it on a ready/valid interface.
- Window is set by base, length and stride; an optional inter-beat gap throttles the stream.
- Supports a 1-cycle-latency SRAM read with full 1-beat/cycle throughput, and reports last/done/busy status.

Parameters:
- DATA_WIDTH, 16, width of each stream word and buffer entry.
- DEPTH, 1024, buffer entries; must be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), buffer address width (derived).
- LEN_WIDTH, 16, width of the transfer-count config.
- GAP_WIDTH, 4, width of the inter-beat gap config.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_en  in  1  buffer write strobe.
- ld_addr  in  ADDR_WIDTH  buffer write address.
- ld_data  in  DATA_WIDTH  buffer write data.
- start  in  1  begin a transfer; sampled only in IDLE or DONE.
- cfg_base  in  ADDR_WIDTH  first read address; captured on accepted start.
- cfg_len  in  LEN_WIDTH  number of beats; captured on accepted start.
- cfg_stride  in  ADDR_WIDTH  address increment per beat; captured on accepted start.
- cfg_gap  in  GAP_WIDTH  idle cycles after each accepted beat; captured on accepted start.
- data  out  DATA_WIDTH  stream word.
- valid  out  1  stream word valid.
- ready  in  1  downstream accept.
- last  out  1  high with the final beat of a transfer.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level; high in DONE.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; valid=0, last=0, busy=0, done=0, data=0; counters and pipe cleared. Buffer contents are not reset.
- Reset mid-transfer aborts it immediately. No beat is emitted after reset until a new start.
- A beat transfers on the rising edge where valid && ready.
- valid never depends combinationally on ready.
- While valid && !ready, data and last are held stable.
- Buffer read: synchronous, 1-cycle latency.
- A 2-entry output skid buffer sustains 1 beat/cycle with ready=1 and gap=0, and absorbs one in-flight read when ready drops.
- Read issue is stalled when the skid buffer holds 2 entries.
- Addressing: beat i reads (cfg_base + i*cfg_stride) mod DEPTH. Address wraps naturally in ADDR_WIDTH bits; stride 0 repeats one word.
- States:
  - IDLE: start=1 captures config. cfg_len=0 goes to DONE next cycle with no beat; otherwise go to RUN.
  - RUN: issue reads until cfg_len reads are issued, then go to DRAIN.
  - DRAIN: remaining beats are presented. After the last-beat handshake, go to DONE.
  - DONE: done=1. start=1 behaves as in IDLE and clears done on the same edge.
- Latency: start sampled at edge k → first read issued at edge k+1 → valid=1 after edge k+2.
- Gap: after each accepted beat, valid is forced low for cfg_gap cycles; reads may prefetch during the gap.
  - With gap=g and ready=1, beats are spaced g+1 cycles apart.
- last=1 exactly on beat cfg_len-1.
- done rises the cycle after the last handshake.
- start while busy is ignored; captured config is not disturbed.
- ld_en while busy: the write is dropped; buffer unchanged.
- ld_en in IDLE or DONE writes on the edge.
- ld_en and start on the same edge: the write takes effect and the first read sees the new data.
- cfg_len counts up to 2^LEN_WIDTH-1; beats past DEPTH wrap addresses.

Test Plan:
- Load buffer[i]=i+0x100 for i=0..31; base=0, len=32, stride=1, gap=0, ready=1 → valid rises 2 cycles after start; 32 consecutive beats 0x100..0x11F; last on 0x11F; done 1 cycle later; busy low.
- Same load; ready toggles 1,0,0,1 repeating → all 32 beats in order, no drop or duplicate, data/last stable across every stalled cycle.
- DEPTH=1024; base=1020, len=6, stride=2 → reads addresses 1020, 1022, 0, 2, 4, 6 in order, with wrap.
- len=4, gap=3, ready=1 → beats at cycles t, t+4, t+8, t+12; valid low in between; last on the 4th beat.
- len=0 → no valid ever; done=1 the cycle after start; busy never asserts beyond that cycle.
- Mid-transfer (beat 5 of 20): pulse rst; start pulsed and ld_en asserted while busy → valid, busy and done all 0 immediately after rst; the dropped write is absent on readback; a fresh start then streams correctly from beat 0.
